// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, synchronises and
// debounces the rows, and emits a one-cycle key_valid with the encoded key.
module keypad_scanner #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    // The cycle that detected the edge is the first stable cycle, so the
    // state itself needs DEBOUNCE_CYC-1 more; the registered output then
    // lands exactly DEBOUNCE_CYC cycles after that detecting cycle.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(DEBOUNCE_CYC - 2);

    state_t           r_state;
    logic [1:0]       r_col;
    logic [1:0]       r_row;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_sync1;
    logic [3:0]       r_rs;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_key_held;

    state_t           w_state_nxt;
    logic [1:0]       w_col_nxt;
    logic [1:0]       w_row_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_code_nxt;
    logic             w_valid_nxt;
    logic             w_held_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [1:0]       w_low_row;
    logic             w_row_high;

    function automatic logic [3:0] f_encode(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hF;
            4'b11_01: code = 4'd0;
            4'b11_10: code = 4'hE;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_row_high = r_rs[r_row];

    always_comb begin
        if (!r_rs[0])      w_low_row = 2'd0;
        else if (!r_rs[1]) w_low_row = 2'd1;
        else if (!r_rs[2]) w_low_row = 2'd2;
        else               w_low_row = 2'd3;
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_cnt_nxt   = w_cnt_inc;
        w_code_nxt  = r_key_code;
        w_valid_nxt = 1'b0;
        w_held_nxt  = r_key_held;

        case (r_state)
            ST_SCAN: begin
                if (r_cnt >= SCAN_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_rs == 4'b1111) begin
                        w_col_nxt = r_col + 2'd1;
                    end else begin
                        w_row_nxt   = w_low_row;
                        w_state_nxt = ST_DEBOUNCE;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (w_row_high) begin
                    w_cnt_nxt   = '0;
                    w_col_nxt   = r_col + 2'd1;
                    w_state_nxt = ST_SCAN;
                end else if (r_cnt >= STABLE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_code_nxt  = f_encode(r_row, r_col);
                    w_valid_nxt = 1'b1;
                    w_held_nxt  = 1'b1;
                    w_state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                w_cnt_nxt = '0;
                if (w_row_high) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            default: begin
                if (!w_row_high) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_HELD;
                end else if (r_cnt >= STABLE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_held_nxt  = 1'b0;
                    w_col_nxt   = r_col + 2'd1;
                    w_state_nxt = ST_SCAN;
                end
            end
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SCAN;
            r_col       <= 2'd0;
            r_row       <= 2'd0;
            r_cnt       <= '0;
            r_sync1     <= 4'b1111;
            r_rs        <= 4'b1111;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_col       <= w_col_nxt;
            r_row       <= w_row_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sync1     <= rows;
            r_rs        <= r_sync1;
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
            r_key_held  <= w_held_nxt;
        end
    end

    assign cols      = ~(4'b0001 << r_col);
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
